// File: rtl/perceptron_bp_gen2.sv
// ---------------------------------------------------------------------------
// perceptron_bp_gen2
//
// Perceptron branch direction predictor for the fetch stage. A row of signed
// weights is selected by hashing the PC with the global history. The row is
// summed combinationally to form the prediction in F. Resolved branches from
// EX train the row they were predicted from. A speculative global history
// register (GHR) advances on predictions and is repaired on a misprediction.
// After reset the weight table is cleared by a sweep of one row per cycle.
// The table itself has no flop reset.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-low reset
//   pc_f           fetch PC
//   br_en_f        fetch slot holds a conditional branch
//   pred_taken_f   predicted direction (0 while the init sweep runs)
//   ghr_f          GHR snapshot used for this prediction
//   y_f            perceptron sum used for this prediction
//   ready          init sweep complete
//   br_en_ex       resolved conditional branch in EX
//   pc_ex          PC of the resolved branch
//   ghr_ex         GHR snapshot carried with the resolved branch
//   y_ex           perceptron sum carried with the resolved branch
//   taken_ex       actual direction
//   mispredict_ex  actual direction differs from the prediction
//
// Optional build macro PERCEPTRON_BP_STATS_EN adds three saturating 32-bit
// event counters: stat_pred, stat_mispred and stat_train.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module perceptron_bp_gen2 #(
    parameter int HIST_LEN    = 10,
    parameter int TABLE_DEPTH = 1024,
    parameter int PC_BITS     = 10,
    parameter int W_WIDTH     = 8,
    parameter int THETA       = 33,
    localparam int IDX_W      = $clog2(TABLE_DEPTH),
    localparam int S_W        = W_WIDTH + $clog2(HIST_LEN + 1) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_BITS-1:0]  pc_f,
    input  logic                br_en_f,
    output logic                pred_taken_f,
    output logic [HIST_LEN-1:0] ghr_f,
    output logic [S_W-1:0]      y_f,
    output logic                ready,
    input  logic                br_en_ex,
    input  logic [PC_BITS-1:0]  pc_ex,
    input  logic [HIST_LEN-1:0] ghr_ex,
    input  logic [S_W-1:0]      y_ex,
    input  logic                taken_ex,
    input  logic                mispredict_ex
`ifdef PERCEPTRON_BP_STATS_EN
    ,
    output logic [31:0]         stat_pred,
    output logic [31:0]         stat_mispred,
    output logic [31:0]         stat_train
`endif
);

    localparam int ROW_W = (HIST_LEN + 1) * W_WIDTH;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [W_WIDTH-1:0] W_MAX   = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam logic [W_WIDTH-1:0] W_MIN   = {1'b1, {(W_WIDTH-1){1'b0}}};
    localparam logic [S_W-1:0]     THETA_V = S_W'(THETA);
    localparam logic [IDX_W-1:0]   LAST_ROW = IDX_W'(TABLE_DEPTH - 1);

    logic [0:0]          state_q, state_d;
    logic [IDX_W-1:0]    row_cnt_q, row_cnt_d;
    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    logic [ROW_W-1:0]    table_q [TABLE_DEPTH];

    logic [IDX_W-1:0]    idx_f, idx_ex;
    logic [S_W-1:0]      y_raw;
    logic [S_W-1:0]      y_ex_abs;
    logic [ROW_W-1:0]    row_ex, row_upd;
    logic                train_en;

    // The GHR is zero-extended or truncated to the index width before the XOR.
    function automatic logic [IDX_W-1:0] row_index(input logic [PC_BITS-1:0] pc,
                                                   input logic [HIST_LEN-1:0] g);
        logic [IDX_W-1:0] fold;
        fold = '0;
        for (int i = 0; i < IDX_W && i < HIST_LEN; i++) begin
            fold[i] = g[i];
        end
        return pc[IDX_W-1:0] ^ fold;
    endfunction

    // Bias plus history-signed weights. S_W is wide enough that this cannot overflow.
    function automatic logic [S_W-1:0] row_sum(input logic [ROW_W-1:0] row,
                                               input logic [HIST_LEN-1:0] g);
        logic [W_WIDTH-1:0] w;
        logic [S_W-1:0]     ext;
        logic [S_W-1:0]     acc;
        w   = row[W_WIDTH-1:0];
        acc = {{(S_W-W_WIDTH){w[W_WIDTH-1]}}, w};
        for (int i = 1; i <= HIST_LEN; i++) begin
            w   = row[i*W_WIDTH +: W_WIDTH];
            ext = {{(S_W-W_WIDTH){w[W_WIDTH-1]}}, w};
            acc = g[i-1] ? acc + ext : acc - ext;
        end
        return acc;
    endfunction

    function automatic logic [W_WIDTH-1:0] sat_step(input logic [W_WIDTH-1:0] w,
                                                    input logic up);
        if (up) begin
            return (w == W_MAX) ? w : w + W_WIDTH'(1);
        end
        return (w == W_MIN) ? w : w - W_WIDTH'(1);
    endfunction

    assign ready = (state_q == ST_RUN);

    // F-stage prediction. Outputs stay at zero until the table sweep has finished.
    always_comb begin
        idx_f        = row_index(pc_f, ghr_q);
        y_raw        = row_sum(table_q[idx_f], ghr_q);
        pred_taken_f = ready & ~y_raw[S_W-1];
        y_f          = ready ? y_raw : '0;
        ghr_f        = ready ? ghr_q : '0;
    end

    // EX-stage training. Each weight moves toward agreement with the outcome.
    // The bias weight follows the outcome alone. A history weight moves up
    // when its history bit matches the outcome.
    always_comb begin
        idx_ex   = row_index(pc_ex, ghr_ex);
        row_ex   = table_q[idx_ex];
        y_ex_abs = y_ex[S_W-1] ? (~y_ex + S_W'(1)) : y_ex;
        train_en = br_en_ex && ready && (mispredict_ex || (y_ex_abs <= THETA_V));
        row_upd  = '0;
        row_upd[W_WIDTH-1:0] = sat_step(row_ex[W_WIDTH-1:0], taken_ex);
        for (int i = 1; i <= HIST_LEN; i++) begin
            row_upd[i*W_WIDTH +: W_WIDTH] =
                sat_step(row_ex[i*W_WIDTH +: W_WIDTH], taken_ex ~^ ghr_ex[i-1]);
        end
    end

    // Control and history next state. Recovery from EX wins over a same-cycle
    // speculative shift. Any flagged mispredict blocks the shift.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        ghr_d     = ghr_q;
        if (state_q == ST_INIT) begin
            row_cnt_d = row_cnt_q + IDX_W'(1);
            if (row_cnt_q == LAST_ROW) begin
                state_d = ST_RUN;
            end
        end else begin
            if (br_en_ex && mispredict_ex) begin
                ghr_d = {ghr_ex[HIST_LEN-2:0], taken_ex};
            end else if (br_en_f && !mispredict_ex) begin
                ghr_d = {ghr_q[HIST_LEN-2:0], pred_taken_f};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_INIT;
            row_cnt_q <= '0;
            ghr_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            ghr_q     <= ghr_d;
        end
    end

    // The weight table has no reset. The init sweep zeroes it, and training
    // writes it once the sweep is done. Reads are combinational, so a
    // same-row read sees the old weights.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            table_q[row_cnt_q] <= '0;
        end else if (train_en) begin
            table_q[idx_ex] <= row_upd;
        end
    end

`ifdef PERCEPTRON_BP_STATS_EN
    logic [31:0] stat_pred_q, stat_mispred_q, stat_train_q;

    // Event counters hold at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_pred_q    <= '0;
            stat_mispred_q <= '0;
            stat_train_q   <= '0;
        end else if (ready) begin
            if (br_en_f && (stat_pred_q != '1)) begin
                stat_pred_q <= stat_pred_q + 32'd1;
            end
            if (br_en_ex && mispredict_ex && (stat_mispred_q != '1)) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
            if (train_en && (stat_train_q != '1)) begin
                stat_train_q <= stat_train_q + 32'd1;
            end
        end
    end

    assign stat_pred    = stat_pred_q;
    assign stat_mispred = stat_mispred_q;
    assign stat_train   = stat_train_q;
`else
    // Statistics counters are not built.
`endif

endmodule

// File: doc/perceptron_bp_gen2.md
Name: perceptron_bp_gen2

Overview:
- Parametrised perceptron branch direction predictor for the fetch stage.
- Predicts combinationally in F from a hashed PC/global-history row of signed weights.
- Trains in EX from resolved outcomes, maintains a speculative global history register (GHR) with misprediction recovery, and clears its table with a post-reset init sweep instead of a flop-wide reset.

Parameters:
- HIST_LEN, 10, GHR length = number of non-bias weights per row.
- TABLE_DEPTH, 1024, number of rows (power of 2); IDX_W = $clog2(TABLE_DEPTH).
- PC_BITS, 10, PC bits used for hashing (PC_BITS >= IDX_W).
- W_WIDTH, 8, signed weight width.
- THETA, 33, training threshold (floor(1.93*HIST_LEN+14)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- pc_f  in  PC_BITS  fetch PC.
- br_en_f  in  1  fetch slot holds a conditional branch.
- pred_taken_f  out  1  prediction.
- ghr_f  out  HIST_LEN  GHR snapshot used for this prediction (carried down pipe).
- y_f  out  S_W  perceptron sum; S_W = W_WIDTH+$clog2(HIST_LEN+1)+1 (carried down pipe).
- ready  out  1  init sweep complete.
- br_en_ex  in  1  resolved conditional branch in EX.
- pc_ex  in  PC_BITS  its PC.
- ghr_ex  in  HIST_LEN  its carried GHR snapshot.
- y_ex  in  S_W  its carried sum.
- taken_ex  in  1  actual direction.
- mispredict_ex  in  1  actual direction != predicted.

Behaviour:
- Index: idx = pc[IDX_W-1:0] ^ hist_fold, where hist_fold is the GHR zero-extended or truncated to IDX_W. F uses pc_f and the speculative GHR; EX uses pc_ex and ghr_ex.
- Row: weights w0 (bias) .. wHIST_LEN, each signed W_WIDTH.
- Sum: y = w0 + sum over i of (ghr[i-1] ? +wi : -wi), sign-extended to S_W with no overflow.
  - pred = (y >= 0), i.e. a zero sum predicts taken.
  - Combinational, zero latency; pred_taken_f, ghr_f and y_f are valid in the same cycle as pc_f.
- Speculative GHR update: on br_en_f && ready && !mispredict_ex, ghr_spec <= {ghr_spec[HIST_LEN-2:0], pred_taken_f}. The bit order places the newest outcome at bit 0.
- Recovery: on br_en_ex && mispredict_ex && ready, ghr_spec <= {ghr_ex[HIST_LEN-2:0], taken_ex}. Recovery has priority over a same-cycle F shift; that F prediction is still output but does not shift the GHR.
- Train condition: br_en_ex && ready && (mispredict_ex || |y_ex| <= THETA).
  - t = +1 if taken_ex, else -1.
  - w0 += t.
  - wi += t * (ghr_ex[i-1] ? +1 : -1).
  - Each update saturates at +(2^(W_WIDTH-1)-1) / -(2^(W_WIDTH-1)).
  - The row is written at the clock edge, one-cycle write.
- Read/write same row in the same cycle: F reads the old weights; the write is visible from the next cycle.
- FSM:
  - INIT: row counter clears one row per cycle. After row TABLE_DEPTH-1 is cleared, go to RUN. Init takes exactly TABLE_DEPTH cycles.
  - RUN: normal operation; ready = 1.
- In INIT:
  - ready = 0 and pred_taken_f = 0.
  - br_en_f and br_en_ex are ignored: no GHR shift, no training.
- Reset (async, any time, including mid-init or mid-training): state = INIT, row counter = 0, ghr_spec = 0, ready = 0, pred_taken_f = 0, ghr_f = 0, y_f = 0 (outputs forced to 0 until RUN). Table contents are cleared only by the sweep.

Optional Feature:
- PERCEPTRON_BP_STATS_EN defined: adds three output ports, each a 32-bit saturating counter cleared by reset and counting only in RUN.
  - stat_pred (increments on br_en_f).
  - stat_mispred (increments on br_en_ex && mispredict_ex).
  - stat_train (increments on each train event).
- Undefined: these ports and counters do not exist; no other behaviour changes.

Test Plan:
- Reset release with TABLE_DEPTH=1024 -> ready rises exactly 1024 cycles later; pred_taken_f=0 during init; first RUN prediction is taken with y_f=0.
- pc_f=0x005, GHR=0, br_en_f for 3 cycles with all-zero weights -> ghr_f goes 0x000, 0x001, 0x003.
- Train idx row 200 times with taken_ex=1, ghr_ex=0x3FF -> every weight saturates at +127; y recomputed at 11*127=1397; no training once |y|>33 and correct.
- Mispredict with ghr_ex=0x155, taken_ex=0 while br_en_f is high -> next-cycle ghr_spec=0x2AA; F shift suppressed.
- Same-row EX train and F read in one cycle -> F y_f uses pre-update weights; next-cycle read shows +/-1 changes.
- Assert rst mid-init (row 500) and mid-training -> ready=0, outputs 0, full 1024-cycle sweep restarts, table reads all zero afterward.
